// File: rtl/micro_sequencer.sv
// Microprogrammed control unit for the multicycle ARM-subset datapath: upc register, control store, dispatch.
// Latency: outputs are combinational from upc (Moore); upc advances one micro-state per unstalled clock.
// Backpressure: stall=1 holds upc and forces pc_write/ir_write/mem_w/reg_w/instr_done low; selects unchanged.
//
// Ports: clk, reset_n (async active-low), stall, op/funct/rd (IR fields) in;
//        upc, datapath enables/selects, instr_done, illegal (sticky) out.
module micro_sequencer #(
    parameter int               UPC_W = 5,
    parameter logic [UPC_W-1:0] DISP1 = 5'd10,
    parameter logic [UPC_W-1:0] DISP2 = 5'd11
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall,
    input  logic [1:0]       op,
    input  logic [5:0]       funct,
    input  logic [3:0]       rd,
    output logic [UPC_W-1:0] upc,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_w,
    output logic             ir_write,
    output logic             reg_w,
    output logic [1:0]       result_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             alu_op,
    output logic             branch,
    output logic             instr_done,
    output logic             illegal
);

    typedef enum logic [UPC_W-1:0] {
        S_FETCH    = 'd0,
        S_DECODE   = 'd1,
        S_MEMADR   = 'd2,
        S_MEMRD    = 'd3,
        S_MEMWB    = 'd4,
        S_MEMWR    = 'd5,
        S_EXECUTER = 'd6,
        S_EXECUTEI = 'd7,
        S_ALUWB    = 'd8,
        S_BRANCH   = 'd9
    } state_t;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;

    logic [UPC_W-1:0] next_f;
    logic [UPC_W-1:0] next_upc;
    logic             pc_write_c, ir_write_c, mem_w_c, reg_w_c, done_c;
    logic             defined_c;

    // Only the dispatch bits of funct matter here; the rest belong to the datapath.
    logic             unused_funct;
    assign unused_funct = ^funct[4:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Control store plus next-state resolution.
    always_comb begin
        adr_src    = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 1'b0;
        result_src = 2'b00;
        ir_write_c = 1'b0;
        pc_write_c = 1'b0;
        mem_w_c    = 1'b0;
        reg_w_c    = 1'b0;
        branch     = 1'b0;
        done_c     = 1'b0;
        defined_c  = 1'b1;
        next_f     = '0;
        next_upc   = '0;
        state_d    = state_q;
        illegal_d  = illegal_q;

        case (state_q)
            S_FETCH: begin
                alu_src_a = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
                ir_write_c = 1'b1; pc_write_c = 1'b1;
                next_f = UPC_W'(S_DECODE);
            end
            S_DECODE: begin
                alu_src_a = 1'b1; alu_src_b = 2'b10; result_src = 2'b10;
                next_f = DISP1;
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
                next_f = DISP2;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                next_f = UPC_W'(S_MEMWB);
            end
            S_MEMWB: begin
                result_src = 2'b01; reg_w_c = 1'b1; done_c = 1'b1;
                next_f = UPC_W'(S_FETCH);
            end
            S_MEMWR: begin
                adr_src = 1'b1; mem_w_c = 1'b1; done_c = 1'b1;
                next_f = UPC_W'(S_FETCH);
            end
            S_EXECUTER: begin
                alu_op = 1'b1;
                next_f = UPC_W'(S_ALUWB);
            end
            S_EXECUTEI: begin
                alu_src_b = 2'b01; alu_op = 1'b1;
                next_f = UPC_W'(S_ALUWB);
            end
            S_ALUWB: begin
                reg_w_c = 1'b1; done_c = 1'b1;
                next_f = UPC_W'(S_FETCH);
            end
            S_BRANCH: begin
                alu_src_b = 2'b01; result_src = 2'b10; branch = 1'b1; done_c = 1'b1;
                next_f = UPC_W'(S_FETCH);
            end
            default: begin
                // Unreachable encodings: everything off, recover to FETCH.
                defined_c = 1'b0;
                next_f    = '0;
            end
        endcase

        // Writeback targeting r15 redirects the result into the PC.
        if ((state_q == S_MEMWB || state_q == S_ALUWB) && rd == 4'hF) begin
            reg_w_c    = 1'b0;
            pc_write_c = 1'b1;
        end

        if (!defined_c) begin
            illegal_d = 1'b1;
        end

        if (next_f == DISP1) begin
            case (op)
                2'b00:   next_upc = funct[5] ? UPC_W'(S_EXECUTEI) : UPC_W'(S_EXECUTER);
                2'b01:   next_upc = UPC_W'(S_MEMADR);
                2'b10:   next_upc = UPC_W'(S_BRANCH);
                default: next_upc = UPC_W'(S_FETCH);
            endcase
        end else if (next_f == DISP2) begin
            next_upc = funct[0] ? UPC_W'(S_MEMRD) : UPC_W'(S_MEMWR);
        end else begin
            next_upc = next_f;
        end

        if (!stall) begin
            state_d = state_t'(next_upc);
            // Undefined opcode is flagged as the dispatch is actually taken.
            if (next_f == DISP1 && op == 2'b11) begin
                illegal_d = 1'b1;
            end
        end
    end

    assign upc        = state_q;
    assign illegal    = illegal_q;
    assign pc_write   = pc_write_c & ~stall;
    assign ir_write   = ir_write_c & ~stall;
    assign mem_w      = mem_w_c    & ~stall;
    assign reg_w      = reg_w_c    & ~stall;
    assign instr_done = done_c     & ~stall;

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed test-plan cases then randomized instruction stream.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: stall randomly inserted per micro-state; reference holds its position while stalled.
module tb_micro_sequencer;

    logic       clk;
    logic       reset_n;
    logic       stall;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [4:0] upc;
    logic       pc_write, adr_src, mem_w, ir_write, reg_w;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op, branch, instr_done, illegal;

    int n_cmp = 0;
    int n_bad = 0;
    bit m_illegal = 1'b0;

    micro_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .stall      (stall),
        .op         (op),
        .funct      (funct),
        .rd         (rd),
        .upc        (upc),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_w      (mem_w),
        .ir_write   (ir_write),
        .reg_w      (reg_w),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .branch     (branch),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {adr_src, alu_src_a, alu_src_b, alu_op, result_src, ir_write, pc_write, mem_w, reg_w, branch, instr_done}
    function automatic logic [12:0] dut_word();
        return {adr_src, alu_src_a, alu_src_b, alu_op, result_src,
                ir_write, pc_write, mem_w, reg_w, branch, instr_done};
    endfunction

    // Control words transcribed from the micro-program table, don't-cares as 0.
    function automatic logic [12:0] exp_word(input int s, input logic [3:0] rdv, input bit st);
        logic [12:0] w;
        case (s)
            0: w = 13'b0_1_10_0_10_1_1_0_0_0_0;
            1: w = 13'b0_1_10_0_10_0_0_0_0_0_0;
            2: w = 13'b0_0_01_0_00_0_0_0_0_0_0;
            3: w = 13'b1_0_00_0_00_0_0_0_0_0_0;
            4: w = 13'b0_0_00_0_01_0_0_0_1_0_1;
            5: w = 13'b1_0_00_0_00_0_0_1_0_0_1;
            6: w = 13'b0_0_00_1_00_0_0_0_0_0_0;
            7: w = 13'b0_0_01_1_00_0_0_0_0_0_0;
            8: w = 13'b0_0_00_0_00_0_0_0_1_0_1;
            9: w = 13'b0_0_01_0_10_0_0_0_0_1_1;
            default: w = '0;
        endcase
        if ((s == 4 || s == 8) && rdv == 4'hF) begin
            w[4] = 1'b1;   // pc_write
            w[2] = 1'b0;   // reg_w
        end
        if (st) begin
            w[5] = 1'b0; w[4] = 1'b0; w[3] = 1'b0; w[2] = 1'b0; w[0] = 1'b0;
        end
        return w;
    endfunction

    // Micro-state walk of one instruction as a list.
    task automatic build_path(input logic [1:0] o, input logic [5:0] f, output int p[$]);
        p = {};
        p.push_back(0);
        p.push_back(1);
        case (o)
            2'b00: begin p.push_back(f[5] ? 7 : 6); p.push_back(8); end
            2'b01: begin
                p.push_back(2);
                if (f[0]) begin p.push_back(3); p.push_back(4); end
                else p.push_back(5);
            end
            2'b10: p.push_back(9);
            default: ;
        endcase
    endtask

    // Entered at posedge+1 with DUT in FETCH; leaves at posedge+1 with DUT back in FETCH.
    task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                             input bit rand_stall, input int stall_state, input int stall_n);
        int p[$];
        int ns;
        build_path(o, f, p);
        op = o; funct = f; rd = r;
        foreach (p[i]) begin
            if (rand_stall) ns = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            else            ns = (p[i] == stall_state) ? stall_n : 0;
            for (int k = 0; k <= ns; k++) begin
                stall = (k < ns);
                @(negedge clk);
                chk("upc", 32'(upc), 32'(p[i]));
                chk("ctrl", 32'(dut_word()), 32'(exp_word(p[i], r, stall)));
                chk("illegal", 32'(illegal), 32'(m_illegal));
                @(posedge clk);
                #1;
                if (!stall && p[i] == 1 && o == 2'b11) m_illegal = 1'b1;
            end
        end
        stall = 1'b0;
    endtask

    // Hold reset across one posedge so FETCH is re-entered at a cycle boundary.
    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        m_illegal = 1'b0;
        chk("rst_upc", 32'(upc), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [1:0] ro;
        reset_n = 1'b0; stall = 1'b0; op = 2'b00; funct = '0; rd = '0;
        #2;
        chk("por_upc", 32'(upc), 32'd0);
        chk("por_illegal", 32'(illegal), 32'd0);
        chk("por_ctrl", 32'(dut_word()), 32'(exp_word(0, 4'd0, 1'b0)));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // ADD register, LDR to r15, STR stalled twice in MEMWR, B.
        run_instr(2'b00, 6'b001000, 4'd3,  1'b0, -1, 0);
        run_instr(2'b01, 6'b000001, 4'hF,  1'b0, -1, 0);
        run_instr(2'b01, 6'b000000, 4'd2,  1'b0, 5, 2);
        run_instr(2'b10, 6'b000000, 4'd0,  1'b0, -1, 0);
        // Stalls in FETCH and in both dispatch states.
        run_instr(2'b00, 6'b100000, 4'd1,  1'b0, 0, 2);
        run_instr(2'b01, 6'b000001, 4'd5,  1'b0, 1, 1);
        run_instr(2'b01, 6'b000001, 4'd5,  1'b0, 2, 2);

        // Async reset mid-cycle while in MEMRD.
        op = 2'b01; funct = 6'b000001; rd = 4'd7; stall = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("pre_rst_upc", 32'(upc), 32'd3);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_upc", 32'(upc), 32'd0);
        chk("mid_rst_ctrl", 32'(dut_word()), 32'(exp_word(0, 4'd7, 1'b0)));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Undefined op, then the flag must survive later instructions until reset.
        run_instr(2'b11, 6'b010101, 4'd4, 1'b0, -1, 0);
        run_instr(2'b00, 6'b001000, 4'd3, 1'b0, -1, 0);
        run_instr(2'b10, 6'b000000, 4'd0, 1'b0, 8, 1);
        pulse_reset();

        for (int n = 0; n < 80; n++) begin
            ro = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            run_instr(ro, 6'($urandom), ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom),
                      1'b1, -1, 0);
            if (n == 40) pulse_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
